// File: rtl/result_drain_if.sv
// result_drain output stream: one saturated result element per transfer.
// Master drives the word and its tags; slave returns ready.
interface result_drain_if #(
    parameter int OUT_WIDTH = 16,
    parameter int IDX_W     = 4
);
    logic                        m_valid;
    logic                        m_ready;
    logic signed [OUT_WIDTH-1:0] m_data;
    logic [IDX_W-1:0]            m_index;
    logic                        m_last;
    logic                        m_sat;

    modport master (
        output m_valid,
        output m_data,
        output m_index,
        output m_last,
        output m_sat,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_index,
        input  m_last,
        input  m_sat,
        output m_ready
    );
endinterface

// File: rtl/result_drain.sv
// result_drain: captures a systolic multiplier result on done_in and
// streams it row-major with signed saturation to OUT_WIDTH.
module result_drain #(
    parameter  int ARRAY_SIZE = 3,
    parameter  int DATA_WIDTH = 8,
    parameter  int OUT_WIDTH  = 16,
    localparam int ACC        = 2 * DATA_WIDTH,
    localparam int E          = ARRAY_SIZE * ARRAY_SIZE,
    localparam int IDX_W      = $clog2(E)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  done_in,
    input  logic signed [ACC-1:0] result_in [E],
    input  logic                  clear_err,
    result_drain_if.master        m,
    output logic                  busy,
    output logic                  overrun,
    output logic [7:0]            frame_count
);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(E - 1);

    state_t                      state_q, state_d;
    logic signed [ACC-1:0]       buf_q [E];
    logic [IDX_W-1:0]            idx_q, idx_d, nxt_idx;
    logic                        valid_q, valid_d;
    logic signed [OUT_WIDTH-1:0] data_q, data_d;
    logic                        sat_q, sat_d;
    logic                        last_q, last_d;
    logic                        ovr_q;
    logic [7:0]                  frame_q;
    logic                        hs, last_hs;
    logic                        capture, drop, frame_inc;

    // Returns {clamped, value}; fits iff all bits above the sign agree.
    function automatic logic [OUT_WIDTH:0] sat_fn(
        input logic signed [ACC-1:0] v
    );
        logic [ACC-OUT_WIDTH:0] hi;
        hi = v[ACC-1:OUT_WIDTH-1];
        if (&hi || ~|hi)
            sat_fn = {1'b0, v[OUT_WIDTH-1:0]};
        else if (v[ACC-1])
            sat_fn = {2'b11, {(OUT_WIDTH-1){1'b0}}};
        else
            sat_fn = {2'b10, {(OUT_WIDTH-1){1'b1}}};
    endfunction

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        idx_d     = idx_q;
        data_d    = data_q;
        sat_d     = sat_q;
        last_d    = last_q;
        capture   = 1'b0;
        drop      = 1'b0;
        frame_inc = 1'b0;
        nxt_idx   = idx_q + 1'b1;
        hs        = valid_q && m.m_ready;
        last_hs   = hs && (idx_q == LAST_IDX);
        unique case (state_q)
            IDLE: begin
                if (done_in) begin
                    capture          = 1'b1;
                    state_d          = STREAM;
                    valid_d          = 1'b1;
                    idx_d            = '0;
                    {sat_d, data_d}  = sat_fn(result_in[0]);
                    last_d           = (LAST_IDX == '0);
                end
            end
            STREAM: begin
                if (last_hs) begin
                    frame_inc = 1'b1;
                    if (done_in) begin
                        capture         = 1'b1;
                        idx_d           = '0;
                        {sat_d, data_d} = sat_fn(result_in[0]);
                        last_d          = (LAST_IDX == '0);
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    drop = done_in;
                    if (hs) begin
                        idx_d           = nxt_idx;
                        {sat_d, data_d} = sat_fn(buf_q[nxt_idx]);
                        last_d          = (nxt_idx == LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            sat_q   <= 1'b0;
            last_q  <= 1'b0;
            ovr_q   <= 1'b0;
            frame_q <= '0;
            for (int i = 0; i < E; i++) buf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            sat_q   <= sat_d;
            last_q  <= last_d;
            if (capture)
                for (int i = 0; i < E; i++) buf_q[i] <= result_in[i];
            if (frame_inc)
                frame_q <= frame_q + 8'd1;
            if (drop)
                ovr_q <= 1'b1;
            else if (clear_err)
                ovr_q <= 1'b0;
        end
    end

    assign m.m_valid   = valid_q;
    assign m.m_data    = data_q;
    assign m.m_index   = idx_q;
    assign m.m_last    = last_q;
    assign m.m_sat     = sat_q;
    assign busy        = (state_q == STREAM);
    assign overrun     = ovr_q;
    assign frame_count = frame_q;

endmodule

// File: doc/result_drain.md
# result_drain

Downstream stage of the systolic matrix multiplier. Captures the full `ARRAY_SIZE*ARRAY_SIZE` result array on the multiplier's one-cycle `done` pulse and streams it out one element per transfer, in row-major order, over a valid/ready interface. Signed saturation narrows each element to the output width. The capture buffer frees the multiplier to start the next product while the previous result drains.

## Interface
- `ARRAY_SIZE`, 3, matrix dimension N; element count E = N*N.
- `DATA_WIDTH`, 8, multiplier operand width; accumulator width ACC = 2*DATA_WIDTH.
- `OUT_WIDTH`, 16, output element width; legal range 2..ACC.
- `IDX_W`, derived = clogb2(E), width of element index.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `done_in` in 1: one-cycle pulse from the multiplier; `result_in` is valid in that cycle.
- `result_in` in ACC x E (unpacked, signed): element [r*N+c] = C[r][c].
- `clear_err` in 1: clears `overrun`.
- `m_valid` out 1: output word valid.
- `m_ready` in 1: consumer accepts the word.
- `m_data` out OUT_WIDTH signed: saturated element.
- `m_index` out IDX_W: linear index r*N+c of `m_data`.
- `m_last` out 1: high with index E-1.
- `m_sat` out 1: `m_data` was clamped.
- `busy` out 1: high while streaming (state STREAM).
- `overrun` out 1: sticky; set when a result was dropped.
- `frame_count` out 8: number of fully drained matrices, wraps 255->0.

## Operation
- FSM states: IDLE and STREAM.
- **IDLE + `done_in`:**
  - Copy all E elements of `result_in` into the capture buffer.
  - Load output registers with element 0.
  - Set `m_valid`=1 and go to STREAM.
- **STREAM, handshake (`m_valid && m_ready`) with index < E-1:**
  - Increment the index.
  - Load output registers with the next buffered element.
- **STREAM, handshake with index = E-1:**
  - Increment `frame_count`.
  - If `done_in` is high in the same cycle: recapture, load element 0, stay in STREAM with `m_valid`=1 (back-to-back, no bubble).
  - Otherwise: `m_valid`=0 and go to IDLE.
- **STREAM, `done_in` in any cycle other than the last-word handshake:**
  - The new result is dropped and `overrun` is set.
  - The buffer and the current stream are unaffected.
- **Saturation (ACC > OUT_WIDTH):**
  - Values above 2^(OUT_WIDTH-1)-1 clamp to that value; values below -2^(OUT_WIDTH-1) clamp to that value.
  - `m_sat`=1 when clamping occurred.
  - Otherwise the low OUT_WIDTH bits pass through and `m_sat`=0.
- **Saturation (OUT_WIDTH = ACC):** values pass through and `m_sat` is always 0.
- **`overrun` / `clear_err`:**
  - `clear_err` clears `overrun` at the next edge.
  - If a set condition and `clear_err` occur in the same cycle, set wins.
- **Output stability:** while `m_valid`=1 and `m_ready`=0, `m_data`, `m_index`, `m_last` and `m_sat` hold their values.
- `m_valid` never drops without a handshake, except on reset.
- `busy` = (state == STREAM).

## Timing
- All outputs are registered.
- **Reset values:** `m_valid`=0, `m_data`=0, `m_index`=0, `m_last`=0, `m_sat`=0, `busy`=0, `overrun`=0, `frame_count`=0; capture buffer=0; state=IDLE.
- **Latency:** `done_in` at edge t gives `m_valid`=1 with element 0 after edge t+1.
- **Throughput:** one element per cycle with `m_ready` held high. E cycles per matrix, with zero gap for back-to-back `done_in`.
- **Reset mid-stream:** the stream is abandoned with no further words and all outputs return to their reset values. `done_in` in the reset cycle is ignored.
- `m_ready` is ignored while `m_valid`=0.

## Test plan
- **Basic drain:** N=3, OUT_WIDTH=16, result = 1..9, `m_ready`=1. Expect `m_valid` the cycle after `done_in`; data 1..9 on 9 consecutive cycles; `m_index` 0..8; `m_last` only on index 8; then `frame_count`=1, `busy`=0.
- **Backpressure:** same data with `m_ready` toggling 1,0,0,1,... Expect every word held stable while stalled, no word lost or duplicated, order 1..9.
- **Saturation:** OUT_WIDTH=8, elements {300, -300, 127, -128, 128, -129, 0, 5, -5}. Expect `m_data` {127, -128, 127, -128, 127, -128, 0, 5, -5} and `m_sat` {1,1,0,0,1,1,0,0,0}.
- **Back-to-back and overrun:**
  - Pulse a second `done_in` (values 11..19) in the same cycle as the index-8 handshake. Expect 11..19 to follow with no bubble, `overrun`=0.
  - Then pulse a third `done_in` at index 3. Expect it dropped, `overrun`=1, and the stream completing 14..19.
  - Assert `clear_err` in the same cycle as a further drop. Expect `overrun` stays 1; `clear_err` alone then clears it.
- **Reset mid-stream:** assert `rst_n`=0 after index 4 is accepted. Expect all outputs at reset values the next cycle and no further words.
- **Counter wrap:** drain 256 matrices. Expect `frame_count` to go 255 -> 0.
